ls_port_arbiter: RTL and testbench

//  Shares the single data-memory port between the two issue lanes of the dual-issue core.

---
 rtl/ls_arb_pkg.sv | 14 +
 rtl/ls_tag_fifo.sv | 56 +++++
 rtl/ls_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_ls_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_arb_pkg.sv
// rtl/ls_arb_pkg.sv - shared encodings and default widths for the load/store port arbiter
package ls_arb_pkg;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] SECOND = 1'b1;

   localparam logic [0:0] LANE1 = 1'b0;
   localparam logic [0:0] LANE2 = 1'b1;

   localparam int DEF_AW        = 32;
   localparam int DEF_DW        = 32;
   localparam int DEF_MAX_OUTST = 2;

endpackage

// File: rtl/ls_tag_fifo.sv
// rtl/ls_tag_fifo.sv - in-order lane-id FIFO for outstanding loads (head always at mem[0])
module ls_tag_fifo
   import ls_arb_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_OUTST,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [0:0]    push_data,
   input  logic          pop,
   output logic [0:0]    pop_data,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   logic [DEPTH-1:0] mem;
   logic [DEPTH-1:0] mem_nxt;
   logic             do_push;
   logic             do_pop;
   logic [CW-1:0]    wr_idx;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop_data = mem[0];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign wr_idx   = do_pop ? (count - CW'(1)) : count;

   // Shift-down storage: a pop moves every entry toward the head, the push lands behind the last one.
   always_comb begin
      mem_nxt = do_pop ? (mem >> 1) : mem;
      for (int i = 0; i < DEPTH; i++) begin
         if (do_push && (wr_idx == CW'(i))) begin
            mem_nxt[i] = push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem   <= '0;
         count <= '0;
      end else begin
         mem <= mem_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ls_port_arbiter.sv
// rtl/ls_port_arbiter.sv - dual-lane data-memory port arbiter; optional LS_ARB_PERF_CNT_EN adds dual_ls_cnt
module ls_port_arbiter
   import ls_arb_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MAX_OUTST = DEF_MAX_OUTST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            l1_valid,
   input  logic            l1_we,
   input  logic [AW-1:0]   l1_addr,
   input  logic [DW-1:0]   l1_wdata,
   input  logic [DW/8-1:0] l1_be,
   input  logic            l2_valid,
   input  logic            l2_we,
   input  logic [AW-1:0]   l2_addr,
   input  logic [DW-1:0]   l2_wdata,
   input  logic [DW/8-1:0] l2_be,
   output logic            ls_stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata,
   output logic            l1_rvalid,
   output logic [DW-1:0]   l1_rdata,
   output logic            l2_rvalid,
   output logic [DW-1:0]   l2_rdata,
   output logic            arb_err
`ifdef LS_ARB_PERF_CNT_EN
   ,
   output logic [31:0]     dual_ls_cnt
`endif
);

   localparam int CW = $clog2(MAX_OUTST + 1);

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [0:0]    sel_lane;
   logic          both_valid;
   logic          op_valid;
   logic          issue;
   logic          granted;
   logic          resp_ok;
   logic [0:0]    tag_head;
   logic [CW-1:0] tag_count;
   logic          tag_empty;
   logic          tag_full;

   assign both_valid = l1_valid && l2_valid;

   always_comb begin
      sel_lane = LANE1;
      op_valid = 1'b0;
      if (state == SECOND) begin
         sel_lane = LANE2;
         op_valid = l2_valid;
      end else begin
         sel_lane = l1_valid ? LANE1 : LANE2;
         op_valid = l1_valid || l2_valid;
      end
   end

   assign mem_we    = (sel_lane == LANE1) ? l1_we    : l2_we;
   assign mem_addr  = (sel_lane == LANE1) ? l1_addr  : l2_addr;
   assign mem_wdata = (sel_lane == LANE1) ? l1_wdata : l2_wdata;
   assign mem_be    = (sel_lane == LANE1) ? l1_be    : l2_be;

   // Loads wait while every tag slot is taken; a same-cycle pop is deliberately not bypassed.
   assign issue   = op_valid && !(!mem_we && (tag_count == CW'(MAX_OUTST)));
   assign granted = issue && mem_gnt && !rst;
   assign mem_req = issue && !flush && !rst;

   // The older op of a pair always stalls; the pair retires only with its last grant.
   assign ls_stall = !rst && op_valid && (!granted || ((state == IDLE) && both_valid));

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else if (state == IDLE) begin
         if (both_valid && granted) begin
            state_nxt = SECOND;
         end
      end else if (granted || !l2_valid) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         arb_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (mem_rvalid && tag_empty) begin
            arb_err <= 1'b1;
         end
      end
   end

   ls_tag_fifo #(
      .DEPTH (MAX_OUTST),
      .CW    (CW)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (granted && !mem_we && !tag_full),
      .push_data (sel_lane),
      .pop       (mem_rvalid),
      .pop_data  (tag_head),
      .count     (tag_count),
      .empty     (tag_empty),
      .full      (tag_full)
   );

   assign resp_ok   = mem_rvalid && !tag_empty && !rst;
   assign l1_rvalid = resp_ok && (tag_head == LANE1);
   assign l2_rvalid = resp_ok && (tag_head == LANE2);
   assign l1_rdata  = l1_rvalid ? mem_rdata : '0;
   assign l2_rdata  = l2_rvalid ? mem_rdata : '0;

`ifdef LS_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dual_ls_cnt <= '0;
      end else if ((state == IDLE) && (state_nxt == SECOND)) begin
         dual_ls_cnt <= dual_ls_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ls_port_arbiter.sv
// tb/tb_ls_port_arbiter.sv - scoreboard bench for ls_port_arbiter (LS_ARB_PERF_CNT_EN checks the counter)
module tb_ls_port_arbiter;
   import ls_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        l1_valid, l1_we, l2_valid, l2_we;
   logic [31:0] l1_addr, l1_wdata, l2_addr, l2_wdata;
   logic [3:0]  l1_be, l2_be;
   logic        ls_stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        l1_rvalid, l2_rvalid, arb_err;
   logic [31:0] l1_rdata, l2_rdata;
`ifdef LS_ARB_PERF_CNT_EN
   logic [31:0] dual_ls_cnt;
`endif

   always #5 clk = ~clk;

   ls_port_arbiter dut (
      .clk(clk), .rst(rst), .flush(flush),
      .l1_valid(l1_valid), .l1_we(l1_we), .l1_addr(l1_addr), .l1_wdata(l1_wdata), .l1_be(l1_be),
      .l2_valid(l2_valid), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_be(l2_be),
      .ls_stall(ls_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .l1_rvalid(l1_rvalid), .l1_rdata(l1_rdata), .l2_rvalid(l2_rvalid), .l2_rdata(l2_rdata),
      .arb_err(arb_err)
`ifdef LS_ARB_PERF_CNT_EN
      , .dual_ls_cnt(dual_ls_cnt)
`endif
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        stall;
   } req_t;

   typedef struct {
      string       name;
      logic [0:0]  lane;
      logic [31:0] data;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic exp1(input string name, input logic we, input logic [31:0] addr, input logic stall);
      req_q.push_back('{name, we, addr, {16'h1111, addr[15:0]}, 4'hF, stall});
   endtask

   task automatic exp2(input string name, input logic we, input logic [31:0] addr, input logic stall);
      req_q.push_back('{name, we, addr, {16'h2222, addr[15:0]}, 4'h3, stall});
   endtask

   task automatic exp_rsp(input string name, input logic [0:0] lane, input logic [31:0] data);
      rsp_q.push_back('{name, lane, data});
   endtask

   task automatic lanes(input logic v1, input logic w1, input logic [31:0] a1,
                        input logic v2, input logic w2, input logic [31:0] a2);
      l1_valid = v1; l1_we = w1; l1_addr = a1; l1_wdata = {16'h1111, a1[15:0]}; l1_be = 4'hF;
      l2_valid = v2; l2_we = w2; l2_addr = a2; l2_wdata = {16'h2222, a2[15:0]}; l2_be = 4'h3;
   endtask

   task automatic chk1(input string name, input logic got, input logic want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, got, want);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      next();
   endtask

   // Monitor: every cycle the DUT presents a request or a routed response, pop and compare.
   always @(negedge clk) begin
      req_t        e;
      rsp_t        r;
      logic [0:0]  got_lane;
      logic [31:0] got_data;
      if (mem_req === 1'b1) begin
         n_chk++;
         if (req_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected: got addr=%0h we=%b, want no request", mem_addr, mem_we);
         end else begin
            e = req_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.wdata ||
                mem_be !== e.be || ls_stall !== e.stall) begin
               n_fail++;
               $display("FAIL %s: got we=%b addr=%0h wdata=%0h be=%0h stall=%b, want we=%b addr=%0h wdata=%0h be=%0h stall=%b",
                        e.name, mem_we, mem_addr, mem_wdata, mem_be, ls_stall,
                        e.we, e.addr, e.wdata, e.be, e.stall);
            end
         end
      end
      if (l1_rvalid === 1'b1 || l2_rvalid === 1'b1) begin
         n_chk++;
         got_lane = l2_rvalid ? LANE2 : LANE1;
         got_data = l2_rvalid ? l2_rdata : l1_rdata;
         if (rsp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got lane=%0d data=%0h, want no response", got_lane, got_data);
         end else begin
            r = rsp_q.pop_front();
            if ((l1_rvalid && l2_rvalid) || got_lane !== r.lane || got_data !== r.data) begin
               n_fail++;
               $display("FAIL %s: got l1v=%b l2v=%b data=%0h, want lane=%0d data=%0h",
                        r.name, l1_rvalid, l2_rvalid, got_data, r.lane, r.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      lanes(1, 0, 32'h100, 1, 0, 32'h104);
      settle();
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_ls_stall", ls_stall, 1'b0);
      next();
      settle();
      chk1("rst_arb_err", arb_err, 1'b0);
      chk1("rst_l1_rvalid", l1_rvalid, 1'b0);
      chk1("rst_l2_rvalid", l2_rvalid, 1'b0);
      next();
      rst = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
      lanes(0, 0, 0, 0, 0, 0);
      cyc();

      // single l1 load, response two cycles after the grant
      lanes(1, 0, 32'h100, 0, 0, 0); mem_gnt = 1'b1;
      exp1("t1_req", 0, 32'h100, 0);
      cyc();
      lanes(0, 0, 0, 0, 0, 0); mem_gnt = 1'b0;
      cyc();
      mem_rvalid = 1'b1; mem_rdata = 32'hA5;
      exp_rsp("t1_rsp", LANE1, 32'hA5);
      cyc();
      mem_rvalid = 1'b0;

      // store/load pair serialised over two grants
      lanes(1, 1, 32'h10, 1, 0, 32'h20); mem_gnt = 1'b1;
      exp1("t2_c0", 1, 32'h10, 1);
      cyc();
      exp2("t2_c1", 0, 32'h20, 0);
      cyc();
      lanes(0, 0, 0, 0, 0, 0); mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5A;
      exp_rsp("t2_rsp", LANE2, 32'h5A);
      cyc();
      mem_rvalid = 1'b0;

      // two dual-load pairs against a 2-deep tag FIFO
      lanes(1, 0, 32'h30, 1, 0, 32'h34); mem_gnt = 1'b1;
      exp1("t3_a1", 0, 32'h30, 1);
      cyc();
      exp2("t3_a2", 0, 32'h34, 0);
      cyc();
      lanes(1, 0, 32'h38, 1, 0, 32'h3C);
      for (int i = 0; i < 2; i++) begin
         settle();
         chk1("t3_gated_req", mem_req, 1'b0);
         chk1("t3_gated_stall", ls_stall, 1'b1);
         next();
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h1;
      exp_rsp("t3_rsp1", LANE1, 32'h1);
      settle();
      chk1("t3_pop_no_bypass", mem_req, 1'b0);
      chk1("t3_pop_stall", ls_stall, 1'b1);
      next();
      mem_rvalid = 1'b0;
      exp1("t3_b1", 0, 32'h38, 1);
      cyc();
      mem_rvalid = 1'b1; mem_rdata = 32'h2;
      exp_rsp("t3_rsp2", LANE2, 32'h2);
      settle();
      chk1("t3_second_gated", mem_req, 1'b0);
      chk1("t3_second_stall", ls_stall, 1'b1);
      next();
      mem_rvalid = 1'b0;
      exp2("t3_b2", 0, 32'h3C, 0);
      cyc();
      lanes(0, 0, 0, 0, 0, 0); mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h3;
      exp_rsp("t3_rsp3", LANE1, 32'h3);
      cyc();
      mem_rdata = 32'h4;
      exp_rsp("t3_rsp4", LANE2, 32'h4);
      cyc();
      mem_rvalid = 1'b0;

      // flush while the second op of a pair waits for its grant
      lanes(1, 0, 32'h40, 1, 1, 32'h44); mem_gnt = 1'b1;
      exp1("t4_l1", 0, 32'h40, 1);
      cyc();
      mem_gnt = 1'b0;
      exp2("t4_wait0", 1, 32'h44, 1);
      cyc();
      exp2("t4_wait1", 1, 32'h44, 1);
      cyc();
      flush = 1'b1;
      settle();
      chk1("t4_flush_req", mem_req, 1'b0);
      next();
      flush = 1'b0;
      lanes(1, 1, 32'h50, 1, 1, 32'h54);
      mem_rvalid = 1'b1; mem_rdata = 32'hCC;
      exp1("t4_idle_after_flush", 1, 32'h50, 1);
      exp_rsp("t4_rsp", LANE1, 32'hCC);
      cyc();
      lanes(0, 0, 0, 0, 0, 0); mem_rvalid = 1'b0;
      cyc();

      // rvalid with empty FIFO, sticky error, reset discards tags
      mem_rvalid = 1'b1; mem_rdata = 32'hEE;
      cyc();
      mem_rvalid = 1'b0;
      settle();
      chk1("t5_err_set", arb_err, 1'b1);
      next();
      settle();
      chk1("t5_err_sticky", arb_err, 1'b1);
      next();
      lanes(1, 0, 32'h60, 0, 0, 0); mem_gnt = 1'b1;
      exp1("t5_load", 0, 32'h60, 0);
      cyc();
      lanes(0, 0, 0, 0, 0, 0); mem_gnt = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      settle();
      chk1("t5_rst_err", arb_err, 1'b0);
      chk1("t5_rst_req", mem_req, 1'b0);
      chk1("t5_rst_stall", ls_stall, 1'b0);
      next();
      mem_rvalid = 1'b1; mem_rdata = 32'h77;
      cyc();
      mem_rvalid = 1'b0;
      settle();
      chk1("t5_tag_discarded", arb_err, 1'b1);
      next();
      rst = 1'b1;
      cyc();
      rst = 1'b0;

      // dual-LS counting and an l2-only op issued from IDLE
`ifdef LS_ARB_PERF_CNT_EN
      settle();
      chk32("t6_cnt_reset", dual_ls_cnt, 32'd0);
      next();
`endif
      mem_gnt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lanes(1, 1, 32'h80 + 32'(16 * k), 1, 1, 32'h84 + 32'(16 * k));
         exp1("t6_pair_l1", 1, 32'h80 + 32'(16 * k), 1);
         cyc();
         exp2("t6_pair_l2", 1, 32'h84 + 32'(16 * k), 0);
         cyc();
      end
      lanes(0, 0, 0, 1, 1, 32'h70);
      exp2("t6_l2_only", 1, 32'h70, 0);
      settle();
`ifdef LS_ARB_PERF_CNT_EN
      chk32("t6_cnt_three", dual_ls_cnt, 32'd3);
`endif
      next();
      lanes(0, 0, 0, 0, 0, 0); mem_gnt = 1'b0;
      settle();
`ifdef LS_ARB_PERF_CNT_EN
      chk32("t6_cnt_single_unchanged", dual_ls_cnt, 32'd3);
`endif
      next();
      cyc();

      chk32("end_req_q_drained", 32'(req_q.size()), 32'd0);
      chk32("end_rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
